// File: rtl/fnd_scan_driver.sv
// Multiplexed common-anode seven-segment scanner with shadowed BCD/DP data,
// leading-zero blanking, dash glyph for non-BCD codes and a frame-done pulse.
module fnd_scan_driver #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned DIGIT_PERIOD = 100000
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_En,
  input  logic                  i_Load,
  input  logic [4*DIGITS-1:0]   i_Value,
  input  logic [DIGITS-1:0]     i_DP,
  input  logic                  i_BlankLZ,
  output logic [DIGITS-1:0]     o_FND_Digit,
  output logic [7:0]            o_FND_Font,
  output logic                  o_FrameDone
);

  localparam int unsigned PW = (DIGIT_PERIOD > 2) ? $clog2(DIGIT_PERIOD) : 1;
  localparam int unsigned IW = (DIGITS > 2) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] CNT_LAST = PW'(DIGIT_PERIOD - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [PW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   val_sh;
  logic [DIGITS-1:0]     dp_sh;

  logic                  terminal;
  logic                  lead_zero;
  logic [DIGITS-1:0]     blank;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blank;
  logic [DIGITS-1:0]     digit_nxt;
  logic [7:0]            font_nxt;

  // Active-low a..g pattern; non-BCD codes render as a lone g-segment dash.
  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h3F;
    endcase
    return seg;
  endfunction

  assign terminal = (cnt == CNT_LAST);

  // Prescaler and scan index; frame-done marks the last-digit -> digit-0 wrap.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt         <= '0;
      idx         <= '0;
      o_FrameDone <= 1'b0;
    end else begin
      cnt         <= terminal ? '0 : cnt + PW'(1);
      o_FrameDone <= terminal && (idx == IDX_LAST);
      if (terminal) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      val_sh <= '0;
      dp_sh  <= '0;
    end else if (i_Load) begin
      val_sh <= i_Value;
      dp_sh  <= i_DP;
    end
  end

  // A digit is blanked while it and every more-significant nibble are zero.
  always_comb begin
    blank     = '0;
    lead_zero = i_BlankLZ;
    for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
      lead_zero = lead_zero & (val_sh[4*k +: 4] == 4'd0);
      blank[k]  = lead_zero;
    end
  end

  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    digit_nxt = '1;
    font_nxt  = 8'hFF;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (idx == IW'(k)) begin
        cur_nib   = val_sh[4*k +: 4];
        cur_dp    = dp_sh[k];
        cur_blank = blank[k];
      end
    end
    if (i_En) begin
      for (int k = 0; k < int'(DIGITS); k++) begin
        digit_nxt[k] = (idx != IW'(k));
      end
      font_nxt = {~cur_dp, cur_blank ? 7'h7F : glyph(cur_nib)};
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_FND_Digit <= '1;
      o_FND_Font  <= 8'hFF;
    end else begin
      o_FND_Digit <= digit_nxt;
      o_FND_Font  <= font_nxt;
    end
  end

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Scoreboard bench for fnd_scan_driver: a cycle-count reference model pushes
// expected outputs at each edge, a negedge monitor pops and compares.
module tb_fnd_scan_driver;

  localparam int D = 4;
  localparam int P = 4;

  logic           clk;
  logic           rst_n;
  logic           en;
  logic           load;
  logic [4*D-1:0] value;
  logic [D-1:0]   dp;
  logic           blz;
  logic [D-1:0]   fnd_digit;
  logic [7:0]     fnd_font;
  logic           frame_done;

  fnd_scan_driver #(.DIGITS(D), .DIGIT_PERIOD(P)) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_En        (en),
    .i_Load      (load),
    .i_Value     (value),
    .i_DP        (dp),
    .i_BlankLZ   (blz),
    .o_FND_Digit (fnd_digit),
    .o_FND_Font  (fnd_font),
    .o_FrameDone (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [D-1:0] dig;
    logic [7:0]   font;
    logic         fd;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;

  // Reference state: edges since reset release plus the loaded digits.
  int unsigned n_edges;
  logic [3:0]  sh_val [D];
  logic        sh_dp  [D];

  function automatic logic [6:0] ref_glyph(input logic [3:0] c);
    case (c)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  task automatic model_reset();
    n_edges = 0;
    for (int k = 0; k < D; k++) begin
      sh_val[k] = 4'd0;
      sh_dp[k]  = 1'b0;
    end
    q.delete();
  endtask

  // Expected output for each edge is derived from elapsed-cycle arithmetic.
  always @(posedge clk) begin
    if (rst_n) begin
      exp_t e;
      int   cur;
      int   msd;
      cur = int'((n_edges / P) % D);
      msd = 0;
      for (int k = 0; k < D; k++) if (sh_val[k] != 4'd0) msd = k;
      e.dig  = '1;
      e.font = 8'hFF;
      if (en) begin
        e.dig[cur] = 1'b0;
        e.font = {~sh_dp[cur], (blz && cur > msd) ? 7'h7F : ref_glyph(sh_val[cur])};
      end
      e.fd = ((n_edges % (P * D)) == P * D - 1);
      q.push_back(e);
      n_edges++;
      if (load) begin
        for (int k = 0; k < D; k++) begin
          sh_val[k] = value[4*k +: 4];
          sh_dp[k]  = dp[k];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      checks++;
      if (fnd_digit !== '1 || fnd_font !== 8'hFF || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: digit=%b font=%h fd=%b expected digit=1111 font=ff fd=0",
                 fnd_digit, fnd_font, frame_done);
      end
    end else if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty: no expectation queued at t=%0t", $time);
    end else begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (fnd_digit !== e.dig || fnd_font !== e.font || frame_done !== e.fd) begin
        errors++;
        $display("FAIL sb_cycle t=%0t: digit=%b font=%h fd=%b expected digit=%b font=%h fd=%b",
                 $time, fnd_digit, fnd_font, frame_done, e.dig, e.font, e.fd);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_now(input logic [D-1:0] ed, input logic [7:0] ef, input string name);
    checks++;
    if (fnd_digit !== ed || fnd_font !== ef) begin
      errors++;
      $display("FAIL %s: digit=%b font=%h expected digit=%b font=%h", name, fnd_digit, fnd_font, ed, ef);
    end
  endtask

  // Wait (bounded) until digit d is enabled, then check its font.
  task automatic show_check(input int d, input logic [7:0] ef, input string name);
    logic [D-1:0] ed;
    bit           found;
    ed     = '1;
    ed[d]  = 1'b0;
    found  = 0;
    for (int i = 0; i < 40; i++) begin
      if (fnd_digit === ed) begin
        found = 1;
        break;
      end
      step();
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: digit=%b never reached expected digit=%b", name, fnd_digit, ed);
    end else begin
      check_now(ed, ef, name);
    end
  endtask

  task automatic do_load(input logic [4*D-1:0] v, input logic [D-1:0] p);
    value = v;
    dp    = p;
    load  = 1'b1;
    step();
    load  = 1'b0;
    step();
  endtask

  task automatic reset_pulse(input bit directed);
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_now('1, 8'hFF, "reset_async");
    @(negedge clk);
    #2 rst_n = 1'b1;
    if (directed) begin
      for (int i = 0; i < P; i++) begin
        step();
        check_now(4'b1110, 8'hC0, "post_reset_digit0");
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    load  = 1'b0;
    value = '0;
    dp    = '0;
    blz   = 1'b0;
    model_reset();
    repeat (3) step();
    #2 rst_n = 1'b1;
    step();
    check_now(4'b1110, 8'hC0, "release_digit0");

    do_load(16'h1234, 4'b0000);
    show_check(0, 8'h99, "cnt_d0");
    show_check(1, 8'hB0, "cnt_d1");
    show_check(2, 8'hA4, "cnt_d2");
    show_check(3, 8'hF9, "cnt_d3");

    blz = 1'b1;
    do_load(16'h0050, 4'b0000);
    show_check(0, 8'hC0, "lz50_d0");
    show_check(1, 8'h92, "lz50_d1");
    show_check(2, 8'hFF, "lz50_d2");
    show_check(3, 8'hFF, "lz50_d3");
    do_load(16'h0000, 4'b0000);
    show_check(0, 8'hC0, "lz0_d0");
    show_check(1, 8'hFF, "lz0_d1");
    show_check(3, 8'hFF, "lz0_d3");
    do_load(16'h0A00, 4'b0000);
    show_check(1, 8'hC0, "lzA_d1");
    show_check(2, 8'hBF, "lzA_d2");
    show_check(3, 8'hFF, "lzA_d3");

    blz = 1'b0;
    do_load(16'h000B, 4'b0001);
    show_check(0, 8'h3F, "inv_dp_d0");
    show_check(1, 8'hC0, "inv_dp_d1");

    show_check(2, 8'hC0, "en_pre_d2");
    en = 1'b0;
    step();
    check_now('1, 8'hFF, "en_off");
    do_load(16'h7000, 4'b1000);
    repeat (P * D) step();
    en = 1'b1;
    show_check(3, 8'h78, "en_load_d3");

    show_check(2, 8'hC0, "rst_pre_d2");
    reset_pulse(1);

    // Randomised traffic; collisions of loads with digit advances arise naturally.
    for (int c = 0; c < 2000; c++) begin
      step();
      en   = ($urandom_range(9, 0) != 0);
      load = ($urandom_range(5, 0) == 0);
      blz  = $urandom_range(1, 0) != 0;
      dp   = D'($urandom_range(15, 0));
      for (int k = 0; k < D; k++)
        value[4*k +: 4] = ($urandom_range(1, 0) == 0) ? 4'd0 : 4'($urandom_range(15, 0));
      if ($urandom_range(299, 0) == 0) begin
        load = 1'b0;
        reset_pulse(0);
      end
    end
    load = 1'b0;
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
